// File: rtl/ram_2p_clr_pkg.sv
// ram_2p_clr_pkg: shared collision-mode and clear-FSM encodings for ram_2p_clr
//   COLL_RD_OLD / COLL_WR_THRU : cross-port read-during-write selection
//   RAM_CLR_IDLE / RAM_CLR_RUN : clear engine state encodings
package ram_2p_clr_pkg;
    localparam int COLL_RD_OLD  = 0;
    localparam int COLL_WR_THRU = 1;
    localparam logic [0:0] RAM_CLR_IDLE = 1'b0;
    localparam logic [0:0] RAM_CLR_RUN  = 1'b1;
endpackage

// File: rtl/ram_2p_clr_rdpipe.sv
// ram_2p_clr_rdpipe: per-port read data/valid pipeline with 1 or 2 cycles of latency
//   clk, rstn : clock, async active-low reset
//   i_en      : read accepted this cycle
//   i_data    : word read from the array this cycle
//   o_data    : read data, holds last value between reads, 0 after reset
//   o_vld     : one-cycle valid per read
module ram_2p_clr_rdpipe #(
    parameter int WIDTH  = 32,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_vld
);
    logic [WIDTH-1:0] r_d1;
    logic             r_v1;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_d1 <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= i_en;
            if (i_en) r_d1 <= i_data;
        end
    end
    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [WIDTH-1:0] r_d2;
            logic             r_v2;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_d2 <= '0;
                    r_v2 <= 1'b0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) r_d2 <= r_d1;
                end
            end
            assign o_data = r_d2;
            assign o_vld  = r_v2;
        end else begin : g_lat1
            assign o_data = r_d1;
            assign o_vld  = r_v1;
        end
    endgenerate
endmodule

// File: rtl/ram_2p_clr.sv
// ram_2p_clr: single-clock true dual-port RAM with byte masks, collision control and clear engine
//   clk, rstn                 : clock, async active-low reset
//   clr_i / busy_o            : clear start pulse / clear in progress
//   cen*_i, wen*_i, bwen*_i   : low-active chip, write and byte-write enables per port
//   addr*_i, data*_i          : address and write data per port
//   data*_o, vld*_o           : read data and one-cycle valid per port, RD_LAT cycles after the read
module ram_2p_clr
    import ram_2p_clr_pkg::*;
#(
    parameter int                    WORD_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    RD_LAT     = 1,
    parameter int                    COLL_MODE  = COLL_RD_OLD,
    parameter logic [WORD_WIDTH-1:0] CLR_VAL    = '0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clr_i,
    output logic                    busy_o,
    input  logic                    cena_i,
    input  logic                    wena_i,
    input  logic [WORD_WIDTH/8-1:0] bwena_i,
    input  logic [ADDR_WIDTH-1:0]   addra_i,
    input  logic [WORD_WIDTH-1:0]   dataa_i,
    output logic [WORD_WIDTH-1:0]   dataa_o,
    output logic                    vlda_o,
    input  logic                    cenb_i,
    input  logic                    wenb_i,
    input  logic [WORD_WIDTH/8-1:0] bwenb_i,
    input  logic [ADDR_WIDTH-1:0]   addrb_i,
    input  logic [WORD_WIDTH-1:0]   datab_i,
    output logic [WORD_WIDTH-1:0]   datab_o,
    output logic                    vldb_o
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int NB    = WORD_WIDTH / 8;
    logic [WORD_WIDTH-1:0] r_mem [DEPTH];
    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  w_busy, w_wa, w_ra, w_wb, w_rb, w_same;
    logic [WORD_WIDTH-1:0] w_bm_a, w_bm_b, w_old_a, w_old_b;
    logic [WORD_WIDTH-1:0] w_mrg_a, w_mrg_b, w_mrg_ab, w_rd_a, w_rd_b;
    // Expand low-active byte enables into a high-active bit mask
    for (genvar i = 0; i < NB; i++) begin : g_bm
        assign w_bm_a[8*i +: 8] = {8{~bwena_i[i]}};
        assign w_bm_b[8*i +: 8] = {8{~bwenb_i[i]}};
    end
    assign w_busy  = r_state == RAM_CLR_RUN;
    assign busy_o  = w_busy;
    assign w_wa    = !w_busy && !cena_i && !wena_i;
    assign w_ra    = !w_busy && !cena_i &&  wena_i;
    assign w_wb    = !w_busy && !cenb_i && !wenb_i;
    assign w_rb    = !w_busy && !cenb_i &&  wenb_i;
    assign w_same  = addra_i == addrb_i;
    assign w_old_a = r_mem[addra_i];
    assign w_old_b = r_mem[addrb_i];
    assign w_mrg_a = (w_old_a & ~w_bm_a) | (dataa_i & w_bm_a);
    assign w_mrg_b = (w_old_b & ~w_bm_b) | (datab_i & w_bm_b);
    // Both ports writing one word: A's bytes are laid over B's merged word
    assign w_mrg_ab = (w_mrg_b & ~w_bm_a) | (dataa_i & w_bm_a);
    assign w_rd_a   = (COLL_MODE == COLL_WR_THRU && w_wb && w_same) ? w_mrg_b : w_old_a;
    assign w_rd_b   = (COLL_MODE == COLL_WR_THRU && w_wa && w_same) ? w_mrg_a : w_old_b;
    // Array contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (w_busy) r_mem[r_cnt] <= CLR_VAL;
        else begin
            if (w_wb) r_mem[addrb_i] <= w_mrg_b;
            if (w_wa) r_mem[addra_i] <= (w_wb && w_same) ? w_mrg_ab : w_mrg_a;
        end
    end
    // Clear engine: one word per cycle, finishes after the all-ones address
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= RAM_CLR_IDLE;
            r_cnt   <= '0;
        end else if (w_busy) begin
            if (&r_cnt) r_state <= RAM_CLR_IDLE;
            else r_cnt <= r_cnt + 1'b1;
        end else if (clr_i) begin
            r_state <= RAM_CLR_RUN;
            r_cnt   <= '0;
        end
    end
    ram_2p_clr_rdpipe #(.WIDTH(WORD_WIDTH), .RD_LAT(RD_LAT)) u_rdpipe_a (
        .clk(clk), .rstn(rstn), .i_en(w_ra), .i_data(w_rd_a), .o_data(dataa_o), .o_vld(vlda_o)
    );
    ram_2p_clr_rdpipe #(.WIDTH(WORD_WIDTH), .RD_LAT(RD_LAT)) u_rdpipe_b (
        .clk(clk), .rstn(rstn), .i_en(w_rb), .i_data(w_rd_b), .o_data(datab_o), .o_vld(vldb_o)
    );
endmodule

// File: tb/tb_ram_2p_clr.sv
// tb_ram_2p_clr: three ram_2p_clr configurations on shared stimulus, checked against a behavioural model
module tb_ram_2p_clr;
    logic        clk = 1'b0, rstn = 1'b0, clr = 1'b0;
    logic        cena = 1'b1, wena = 1'b1, cenb = 1'b1, wenb = 1'b1;
    logic [3:0]  bwena = '1, bwenb = '1;
    logic [7:0]  addra = '0, addrb = '0;
    logic [31:0] dataa = '0, datab = '0;
    logic [31:0] da_o [3];
    logic [31:0] db_o [3];
    logic        va_o [3];
    logic        vb_o [3];
    logic        bsy  [3];
    int n_tests = 0, n_fail = 0;
    always #5 clk = ~clk;

    // u0: 256 words, latency 1, read-old; u1: 256 words, latency 2, write-through; u2: 16 words, latency 2, read-old
    ram_2p_clr #(.WORD_WIDTH(32), .ADDR_WIDTH(8), .RD_LAT(1), .COLL_MODE(0), .CLR_VAL(32'hA5)) u0 (
        .clk(clk), .rstn(rstn), .clr_i(clr), .busy_o(bsy[0]),
        .cena_i(cena), .wena_i(wena), .bwena_i(bwena), .addra_i(addra), .dataa_i(dataa), .dataa_o(da_o[0]), .vlda_o(va_o[0]),
        .cenb_i(cenb), .wenb_i(wenb), .bwenb_i(bwenb), .addrb_i(addrb), .datab_i(datab), .datab_o(db_o[0]), .vldb_o(vb_o[0]));
    ram_2p_clr #(.WORD_WIDTH(32), .ADDR_WIDTH(8), .RD_LAT(2), .COLL_MODE(1), .CLR_VAL(32'hA5)) u1 (
        .clk(clk), .rstn(rstn), .clr_i(clr), .busy_o(bsy[1]),
        .cena_i(cena), .wena_i(wena), .bwena_i(bwena), .addra_i(addra), .dataa_i(dataa), .dataa_o(da_o[1]), .vlda_o(va_o[1]),
        .cenb_i(cenb), .wenb_i(wenb), .bwenb_i(bwenb), .addrb_i(addrb), .datab_i(datab), .datab_o(db_o[1]), .vldb_o(vb_o[1]));
    ram_2p_clr #(.WORD_WIDTH(32), .ADDR_WIDTH(4), .RD_LAT(2), .COLL_MODE(0), .CLR_VAL(32'hA5)) u2 (
        .clk(clk), .rstn(rstn), .clr_i(clr), .busy_o(bsy[2]),
        .cena_i(cena), .wena_i(wena), .bwena_i(bwena), .addra_i(addra[3:0]), .dataa_i(dataa), .dataa_o(da_o[2]), .vlda_o(va_o[2]),
        .cenb_i(cenb), .wenb_i(wenb), .bwenb_i(bwenb), .addrb_i(addrb[3:0]), .datab_i(datab), .datab_o(db_o[2]), .vldb_o(vb_o[2]));

    // Behavioural model: word arrays, a clear countdown, and read results parked in a slot per due cycle
    localparam int AWK [3] = '{8, 8, 4};
    localparam int LATK[3] = '{1, 2, 2};
    localparam int COLK[3] = '{0, 1, 0};
    logic [31:0] mm [3][256];
    int          clr_left [3];
    int          cyc = 0;
    logic [31:0] sda [3][4];
    logic [31:0] sdb [3][4];
    logic        sva [3][4];
    logic        svb [3][4];
    logic [31:0] xda [3];
    logic [31:0] xdb [3];
    logic        xva [3];
    logic        xvb [3];
    logic [200:0] obs;

    always_comb begin
        obs = '0;
        for (int k = 0; k < 3; k++) obs[200-67*k -: 67] = {va_o[k], da_o[k], vb_o[k], db_o[k], bsy[k]};
    end

    function automatic logic [31:0] mrg(input logic [31:0] old, input logic [31:0] d, input logic [3:0] bwen);
        mrg = old;
        for (int i = 0; i < 4; i++) if (!bwen[i]) mrg[8*i +: 8] = d[8*i +: 8];
    endfunction

    function automatic logic [200:0] exp_vec();
        logic [200:0] r;
        r = '0;
        for (int k = 0; k < 3; k++) r[200-67*k -: 67] = {xva[k], xda[k], xvb[k], xdb[k], clr_left[k] != 0};
        return r;
    endfunction

    task automatic model_rst();
        for (int k = 0; k < 3; k++) begin
            clr_left[k] = 0;
            xda[k] = '0; xdb[k] = '0; xva[k] = 1'b0; xvb[k] = 1'b0;
            for (int s = 0; s < 4; s++) begin sva[k][s] = 1'b0; svb[k][s] = 1'b0; end
        end
    endtask

    task automatic model_clk();
        int m, a, b, s;
        logic wa, ra, wb, rb;
        cyc++;
        for (int k = 0; k < 3; k++) begin
            m  = (1 << AWK[k]) - 1;
            a  = int'(addra) & m;
            b  = int'(addrb) & m;
            wa = clr_left[k] == 0 && !cena && !wena;
            ra = clr_left[k] == 0 && !cena &&  wena;
            wb = clr_left[k] == 0 && !cenb && !wenb;
            rb = clr_left[k] == 0 && !cenb &&  wenb;
            s  = (cyc + LATK[k] - 1) % 4;
            if (ra) begin sva[k][s] = 1'b1; sda[k][s] = (COLK[k] == 1 && wb && a == b) ? mrg(mm[k][b], datab, bwenb) : mm[k][a]; end
            if (rb) begin svb[k][s] = 1'b1; sdb[k][s] = (COLK[k] == 1 && wa && a == b) ? mrg(mm[k][a], dataa, bwena) : mm[k][b]; end
            if (wb) mm[k][b] = mrg(mm[k][b], datab, bwenb);
            if (wa) mm[k][a] = mrg(mm[k][a], dataa, bwena);
            if (clr_left[k] > 0) begin
                mm[k][m + 1 - clr_left[k]] = 32'hA5;
                clr_left[k]--;
            end else if (clr) clr_left[k] = m + 1;
            s = cyc % 4;
            xva[k] = sva[k][s]; if (sva[k][s]) xda[k] = sda[k][s]; sva[k][s] = 1'b0;
            xvb[k] = svb[k][s]; if (svb[k][s]) xdb[k] = sdb[k][s]; svb[k][s] = 1'b0;
        end
    endtask

    task automatic step();
        if (rstn) model_clk(); else model_rst();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        cena = 1'b1; wena = 1'b1; cenb = 1'b1; wenb = 1'b1; bwena = '1; bwenb = '1; clr = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bsy[0] || bsy[1] || bsy[2]) && n < 400) begin step(); n++; end
        n_tests++;
        if (bsy[0] || bsy[1] || bsy[2]) begin n_fail++; $display("FAIL wait_idle busy=%b%b%b required 000", bsy[0], bsy[1], bsy[2]); end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        model_rst();
        step(); step();
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if ({va_o[k], vb_o[k], bsy[k], da_o[k], db_o[k]} !== 67'd0) begin
                n_fail++; $display("FAIL reset_u%0d got=%h required 0", k, {va_o[k], vb_o[k], bsy[k], da_o[k], db_o[k]});
            end
        end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_clear_reset();
        int cnt;
        clr = 1'b1; step(); clr = 1'b0;
        for (int i = 0; i < 5; i++) step();
        n_tests++;
        if (bsy[2] !== 1'b1) begin n_fail++; $display("FAIL clrrst_busy_before got=%b required 1", bsy[2]); end
        rstn = 1'b0; model_rst();
        #1;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if ({bsy[k], va_o[k], vb_o[k]} !== 3'b000) begin n_fail++; $display("FAIL clrrst_async_u%0d got=%b required 000", k, {bsy[k], va_o[k], vb_o[k]}); end
        end
        step(); rstn = 1'b1;
        clr = 1'b1; step(); clr = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bsy[2]) cnt++;
            n_tests++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL model_clrrst cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
            step();
        end
        n_tests++;
        if (cnt != 16) begin n_fail++; $display("FAIL clrrst_busy_cycles got=%0d required 16", cnt); end
        wait_idle();
    endtask

    task automatic test_clear();
        int cnt;
        clr = 1'b1; step(); clr = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bsy[2]) begin
                cnt++;
                cena = 1'b0; wena = 1'b0; bwena = '0; addra = 8'($urandom_range(0, 15)); dataa = $urandom;
            end else idle();
            n_tests++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL model_clear cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
            step();
        end
        idle();
        n_tests++;
        if (cnt != 16) begin n_fail++; $display("FAIL clear_busy_cycles got=%0d required 16", cnt); end
        for (int a = 0; a < 16; a++) begin
            cenb = 1'b0; wenb = 1'b1; addrb = 8'(a);
            step(); cenb = 1'b1; step();
            n_tests++;
            if (vb_o[2] !== 1'b1 || db_o[2] !== 32'hA5) begin
                n_fail++; $display("FAIL clear_read_%0d got vld=%b data=%h required vld=1 data=000000a5", a, vb_o[2], db_o[2]);
            end
        end
        wait_idle();
    endtask

    task automatic test_basic();
        cena = 1'b0; wena = 1'b0; bwena = 4'b0000; addra = 8'h10; dataa = 32'hDEADBEEF;
        step(); idle();
        cenb = 1'b0; addrb = 8'h10;
        step(); cenb = 1'b1;
        n_tests++;
        if ({vb_o[0], db_o[0], vb_o[1]} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
            n_fail++; $display("FAIL basic_lat_edge1 got u0 vld=%b data=%h u1 vld=%b required 1 deadbeef 0", vb_o[0], db_o[0], vb_o[1]);
        end
        step();
        n_tests++;
        if ({vb_o[0], db_o[0], vb_o[1], db_o[1]} !== {1'b0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL basic_lat_edge2 got u0 %b %h u1 %b %h required 0 deadbeef 1 deadbeef", vb_o[0], db_o[0], vb_o[1], db_o[1]);
        end
        step();
        n_tests++;
        if (vb_o[1] !== 1'b0 || db_o[1] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL basic_lat_edge3 got u1 vld=%b data=%h required 0 deadbeef", vb_o[1], db_o[1]);
        end
        n_tests++;
        if (obs !== exp_vec()) begin n_fail++; $display("FAIL model_basic cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    endtask

    task automatic test_reset_midread();
        cenb = 1'b0; wenb = 1'b1; addrb = 8'h10;
        step(); cenb = 1'b1;
        rstn = 1'b0; model_rst();
        #1;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if ({va_o[k], vb_o[k], db_o[k]} !== 34'd0) begin n_fail++; $display("FAIL midread_rst_u%0d got=%h required 0", k, {va_o[k], vb_o[k], db_o[k]}); end
        end
        step(); rstn = 1'b1; step();
        n_tests++;
        if (vb_o[1] !== 1'b0 || db_o[1] !== 32'h0) begin n_fail++; $display("FAIL midread_dropped got vld=%b data=%h required 0 0", vb_o[1], db_o[1]); end
        n_tests++;
        if (obs !== exp_vec()) begin n_fail++; $display("FAIL model_midread cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    endtask

    task automatic test_mask();
        cena = 1'b0; wena = 1'b0; bwena = 4'b0000; addra = 8'h20; dataa = 32'h11223344;
        step();
        bwena = 4'b1010; dataa = 32'hAABBCCDD;
        step();
        wena = 1'b1;
        step(); idle(); step();
        n_tests++;
        if ({da_o[0], va_o[1], da_o[1]} !== {32'h11BB33DD, 1'b1, 32'h11BB33DD}) begin
            n_fail++; $display("FAIL mask got u0=%h u1 vld=%b data=%h required 11bb33dd 1 11bb33dd", da_o[0], va_o[1], da_o[1]);
        end
        n_tests++;
        if (obs !== exp_vec()) begin n_fail++; $display("FAIL model_mask cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    endtask

    task automatic test_coll();
        cena = 1'b0; wena = 1'b0; bwena = 4'b0000; addra = 8'h30; dataa = 32'h0;
        step();
        dataa = 32'h5A5A5A5A; cenb = 1'b0; wenb = 1'b1; addrb = 8'h30;
        step(); idle(); step();
        n_tests++;
        if (db_o[0] !== 32'h0) begin n_fail++; $display("FAIL coll_read_old got=%h required 00000000", db_o[0]); end
        n_tests++;
        if (vb_o[1] !== 1'b1 || db_o[1] !== 32'h5A5A5A5A) begin
            n_fail++; $display("FAIL coll_write_thru got vld=%b data=%h required 1 5a5a5a5a", vb_o[1], db_o[1]);
        end
        n_tests++;
        if (obs !== exp_vec()) begin n_fail++; $display("FAIL model_coll cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    endtask

    task automatic test_dual();
        cena = 1'b0; wena = 1'b0; bwena = 4'b0011; addra = 8'h40; dataa = 32'hFFFF0000;
        cenb = 1'b0; wenb = 1'b0; bwenb = 4'b0000; addrb = 8'h40; datab = 32'h12345678;
        step(); idle();
        cena = 1'b0; addra = 8'h40;
        step(); idle(); step();
        n_tests++;
        if ({da_o[0], va_o[1], da_o[1]} !== {32'hFFFF5678, 1'b1, 32'hFFFF5678}) begin
            n_fail++; $display("FAIL dual_write got u0=%h u1 vld=%b data=%h required ffff5678 1 ffff5678", da_o[0], va_o[1], da_o[1]);
        end
        n_tests++;
        if (obs !== exp_vec()) begin n_fail++; $display("FAIL model_dual cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    endtask

    task automatic test_random();
        logic [31:0] r;
        for (int i = 0; i < 500; i++) begin
            r = $urandom;
            cena = r[0]; wena = r[1]; bwena = r[5:2]; addra = {5'd0, r[8:6]}; dataa = $urandom;
            cenb = r[9]; wenb = r[10]; bwenb = r[14:11]; addrb = {5'd0, r[17:15]}; datab = $urandom;
            step();
            n_tests++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL model_random cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
        end
        idle();
    endtask

    initial begin
        model_rst();
        test_reset();
        test_clear_reset();
        test_clear();
        test_basic();
        test_reset_midread();
        test_mask();
        test_coll();
        test_dual();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
